// File: rtl/pmod_spi_target_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pmod_spi_target_pkg
// Purpose  : Shared types and constants for the PmodWIFI SPI target model.
//            - state_e       : frame state (IDLE, SHIFT)
//            - SYNC_STAGES   : pin synchronizer depth
//            - BITS_PER_BYTE : SPI bits per byte
//            - FILL_DEFAULT  : byte driven on MISO when no tx data is queued
// Revision : 1.0 - initial release
// ============================================================================
package pmod_spi_target_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int         SYNC_STAGES   = 2;
  localparam int         BITS_PER_BYTE = 8;
  localparam logic [7:0] FILL_DEFAULT  = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/pmod_spi_target_sync.sv
`default_nettype none
// ============================================================================
// Module   : pmod_spi_target_sync
// Purpose  : Multi-stage synchronizer for one asynchronous pin, followed by a
//            registered rise/fall detector.
// Ports    : aclk    - system clock
//            aresetn - asynchronous active-low reset
//            pin_i   - asynchronous pin
//            level_o - synchronized pin level
//            rise_o  - one-cycle pulse, synchronized level rose
//            fall_o  - one-cycle pulse, synchronized level fell
// Revision : 1.0 - initial release
// ============================================================================
module pmod_spi_target_sync
  import pmod_spi_target_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

  // Reset to the pin's idle level so releasing reset does not fake an edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule
`default_nettype wire

// File: rtl/pmod_spi_target.sv
`default_nettype none
// ============================================================================
// Module   : pmod_spi_target
// Purpose  : SPI mode-0 target standing in for the PmodWIFI module. Pins are
//            sampled in the aclk domain; received bytes leave on an rx
//            valid/ready stream, transmit bytes arrive on a tx stream.
// Ports    : aclk, aresetn          - clock, async active-low reset
//            sck_i, ss_n_i, mosi_i  - SPI pins from the initiator
//            miso_o, miso_t         - MISO data and tristate (1 = high-Z)
//            int_o, int_t           - active-low interrupt and its tristate
//            tx_data/valid/ready    - transmit byte stream
//            rx_data/valid/ready    - receive byte stream
//            busy                   - frame in progress
//            rx_overrun/tx_underrun - one-cycle error pulses
// Config   : PMOD_SPI_TARGET_RXFIFO_EN - RX_DEPTH-entry rx FIFO; otherwise a
//            single rx holding register.
// Revision : 1.0 - initial release
// ============================================================================
module pmod_spi_target
  import pmod_spi_target_pkg::*;
#(
  parameter logic [7:0] FILL     = FILL_DEFAULT,
  parameter int         RX_DEPTH = 4
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       sck_i,
  input  logic       ss_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_t,
  output logic       int_o,
  output logic       int_t,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       rx_overrun,
  output logic       tx_underrun
);

  localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

  if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_rx_depth_check
    $error("RX_DEPTH must be a power of two and at least 2");
  end

  logic ss_level, ss_rise, ss_fall;
  logic sck_level_unused, sck_rise, sck_fall;

  pmod_spi_target_sync #(.RESET_VAL(1'b1)) u_sync_ss (
    .aclk(aclk), .aresetn(aresetn), .pin_i(ss_n_i),
    .level_o(ss_level), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  pmod_spi_target_sync #(.RESET_VAL(1'b0)) u_sync_sck (
    .aclk(aclk), .aresetn(aresetn), .pin_i(sck_i),
    .level_o(sck_level_unused), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] tx_hold_q, tx_hold_d;
  logic       tx_full_q, tx_full_d;
  logic       tx_underrun_q, tx_underrun_d;
  logic       rx_overrun_q, rx_overrun_d;
  logic [7:0] rx_byte;
  logic       rx_push, tx_load, rx_full, rx_pop, rx_accept;

  assign mosi    = mosi_sync_q[SYNC_STAGES-1];
  // Byte as it stands once the current MOSI bit is shifted in, so the push on
  // the last rise needs no extra cycle.
  assign rx_byte = {rx_shift_q[6:0], mosi};

  always_comb begin
    mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    tx_hold_d     = tx_hold_q;
    tx_full_d     = tx_full_q;
    tx_underrun_d = 1'b0;
    rx_push       = 1'b0;
    tx_load       = 1'b0;

    // SS rise outranks any SCK edge seen in the same cycle.
    if (ss_rise) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
            tx_load   = 1'b1;
          end
        end
        SHIFT: begin
          if (sck_rise) begin
            rx_shift_d = rx_byte;
            if (bit_cnt_q == LAST_BIT) begin
              rx_push   = 1'b1;
              tx_load   = 1'b1;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else if (sck_fall && bit_cnt_q != 3'd0) begin
            // With bit_cnt at 0 the freshly loaded MSB is already on MISO.
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (tx_load) begin
      if (tx_full_q) begin
        tx_shift_d = tx_hold_q;
        tx_full_d  = 1'b0;
      end else begin
        tx_shift_d    = FILL;
        tx_underrun_d = 1'b1;
      end
    end

    // Only captures while empty, so it never collides with the load above.
    if (tx_valid && !tx_full_q) begin
      tx_hold_d = tx_data;
      tx_full_d = 1'b1;
    end
  end

  assign rx_pop       = rx_valid && rx_ready;
  assign rx_accept    = rx_push && (!rx_full || rx_pop);
  assign rx_overrun_d = rx_push && rx_full && !rx_pop;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mosi_sync_q   <= '0;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= FILL;
      tx_hold_q     <= '0;
      tx_full_q     <= 1'b0;
      tx_underrun_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
    end else begin
      mosi_sync_q   <= mosi_sync_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      tx_hold_q     <= tx_hold_d;
      tx_full_q     <= tx_full_d;
      tx_underrun_q <= tx_underrun_d;
      rx_overrun_q  <= rx_overrun_d;
    end
  end

`ifdef PMOD_SPI_TARGET_RXFIFO_EN
  localparam int         AW      = $clog2(RX_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [RX_DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (rx_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rx_pop)    rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge aclk) begin
    if (rx_accept) mem_q[wr_ptr_q[AW-1:0]] <= rx_byte;
  end

  // Wrap bits differ and indices match: writer is a full lap ahead.
  assign rx_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rx_valid = (wr_ptr_q != rd_ptr_q);
  assign rx_data  = mem_q[rd_ptr_q[AW-1:0]];
`else
  logic [7:0] rx_hold_q, rx_hold_d;
  logic       rx_full_q, rx_full_d;

  always_comb begin
    rx_hold_d = rx_hold_q;
    rx_full_d = rx_full_q;
    if (rx_pop) rx_full_d = 1'b0;
    if (rx_accept) begin
      rx_hold_d = rx_byte;
      rx_full_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_hold_q <= '0;
      rx_full_q <= 1'b0;
    end else begin
      rx_hold_q <= rx_hold_d;
      rx_full_q <= rx_full_d;
    end
  end

  assign rx_full  = rx_full_q;
  assign rx_valid = rx_full_q;
  assign rx_data  = rx_hold_q;
`endif

  assign miso_o      = tx_shift_q[7];
  assign miso_t      = ss_level;
  assign int_o       = ~rx_valid;
  assign int_t       = 1'b0;
  assign tx_ready    = ~tx_full_q;
  assign busy        = (state_q != IDLE);
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_pmod_spi_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmod_spi_target
// Purpose  : Directed self-checking bench for pmod_spi_target. Acts as the SPI
//            initiator at f_sck = f_aclk/8 and as the rx/tx stream partner.
// Config   : PMOD_SPI_TARGET_RXFIFO_EN selects the FIFO-build expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmod_spi_target;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       sck_i = 1'b0;
  logic       ss_n_i = 1'b1;
  logic       mosi_i = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       rx_ready = 1'b0;
  logic       miso_o, miso_t, int_o, int_t, tx_ready, rx_valid, busy;
  logic       rx_overrun, tx_underrun;
  logic [7:0] rx_data;

  pmod_spi_target dut (
    .aclk(aclk), .aresetn(aresetn), .sck_i(sck_i), .ss_n_i(ss_n_i),
    .mosi_i(mosi_i), .miso_o(miso_o), .miso_t(miso_t), .int_o(int_o),
    .int_t(int_t), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .busy(busy), .rx_overrun(rx_overrun),
    .tx_underrun(tx_underrun)
  );

  always #5 aclk = ~aclk;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         und_cnt = 0;
  int         ovr_cnt = 0;
  logic [7:0] rx_q[$];

  // {miso_t, miso_o, int_o, int_t, tx_ready, rx_valid, busy, rx_overrun, tx_underrun}
  localparam logic [8:0] RESET_OUTS = 9'b1_1_1_0_1_0_0_0_0;

  // Handshake values seen at the edge are the pre-update ones.
  always @(posedge aclk) begin
    if (aresetn) begin
      if (tx_underrun) und_cnt++;
      if (rx_overrun) ovr_cnt++;
      if (rx_valid && rx_ready) rx_q.push_back(rx_data);
    end
  end

  task automatic put_tx(input logic [7:0] b);
    @(negedge aclk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge aclk);
    tx_valid = 1'b0;
  endtask

  task automatic ss_low();
    @(negedge aclk);
    ss_n_i = 1'b0;
    repeat (4) @(negedge aclk);
  endtask

  task automatic ss_high();
    repeat (4) @(negedge aclk);
    ss_n_i = 1'b1;
    repeat (6) @(negedge aclk);
  endtask

  // MSB-first, 4 aclk low then 4 aclk high per bit; MISO captured just before
  // each SCK rise, as the initiator would.
  task automatic xfer_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi_i = mo[i];
      repeat (4) @(negedge aclk);
      mi[i] = miso_o;
      sck_i = 1'b1;
      repeat (4) @(negedge aclk);
      sck_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge aclk);
    n_cmp++;
    if ({miso_t, miso_o, int_o, int_t, tx_ready, rx_valid, busy, rx_overrun, tx_underrun} !== RESET_OUTS) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want %b",
               {miso_t, miso_o, int_o, int_t, tx_ready, rx_valid, busy, rx_overrun, tx_underrun}, RESET_OUTS);
    end
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
  endtask

  task automatic test_one_byte();
    logic [7:0] mi;
    rx_ready = 1'b0;
    rx_q.delete();
    put_tx(8'h3C);
    n_cmp++;
    if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL tx_ready_after_capture: got %b want 0", tx_ready); end
    ss_low();
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_frame: got %b want 1", busy); end
    n_cmp++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_ready_after_load: got %b want 1", tx_ready); end
    xfer_bits(8'hA5, 8, mi);
    n_cmp++;
    if (mi !== 8'h3C) begin n_fail++; $display("FAIL one_byte_miso: got %h want 3c", mi); end
    n_cmp++;
    if ({rx_valid, rx_data, int_o} !== {1'b1, 8'hA5, 1'b0}) begin
      n_fail++;
      $display("FAIL one_byte_rx: got valid=%b data=%h int=%b want 1 a5 0", rx_valid, rx_data, int_o);
    end
    ss_high();
    n_cmp++;
    if ({busy, int_o} !== 2'b00) begin n_fail++; $display("FAIL after_frame: got busy,int=%b want 00", {busy, int_o}); end
    @(negedge aclk); rx_ready = 1'b1;
    @(negedge aclk); rx_ready = 1'b0;
    n_cmp++;
    if ({rx_valid, int_o} !== 2'b01 || rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      n_fail++;
      $display("FAIL one_byte_pop: got valid,int=%b count=%0d want 01 count=1 byte a5", {rx_valid, int_o}, rx_q.size());
    end
  endtask

  task automatic test_underrun();
    logic [7:0] mi;
    logic [7:0] mo[3] = '{8'h11, 8'h22, 8'h33};
    rx_ready = 1'b1;
    rx_q.delete();
    und_cnt = 0;
    ss_low();
    for (int b = 0; b < 3; b++) begin
      xfer_bits(mo[b], 8, mi);
      n_cmp++;
      if (mi !== 8'hFF) begin n_fail++; $display("FAIL underrun_miso_%0d: got %h want ff", b, mi); end
    end
    // Loads that fed the three bytes: SS fall plus the reloads after bytes 1, 2.
    n_cmp++;
    if (und_cnt != 3) begin n_fail++; $display("FAIL underrun_pulses_used: got %0d want 3", und_cnt); end
    ss_high();
    // The reload after byte 3 also finds the holding register empty.
    n_cmp++;
    if (und_cnt != 4) begin n_fail++; $display("FAIL underrun_pulses_total: got %0d want 4", und_cnt); end
    n_cmp++;
    if (rx_q.size() != 3 || rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22 || rx_q[2] !== 8'h33) begin
      n_fail++;
      $display("FAIL underrun_rx_order: got count=%0d want 11 22 33", rx_q.size());
    end
  endtask

  task automatic test_overrun();
    logic [7:0] mi;
    logic [7:0] exp_b[$];
    int         exp_ovr;
`ifdef PMOD_SPI_TARGET_RXFIFO_EN
    exp_b   = '{8'h01, 8'h02, 8'h03, 8'h04};
    exp_ovr = 2;
`else
    exp_b   = '{8'h01};
    exp_ovr = 5;
`endif
    rx_ready = 1'b0;
    rx_q.delete();
    ovr_cnt = 0;
    ss_low();
    for (int b = 1; b <= 6; b++) xfer_bits(8'(b), 8, mi);
    ss_high();
    n_cmp++;
    if (ovr_cnt != exp_ovr) begin n_fail++; $display("FAIL overrun_pulses: got %0d want %0d", ovr_cnt, exp_ovr); end
    @(negedge aclk); rx_ready = 1'b1;
    repeat (8) @(negedge aclk);
    n_cmp++;
    if (rx_q.size() != exp_b.size()) begin
      n_fail++;
      $display("FAIL overrun_count: got %0d want %0d", rx_q.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < rx_q.size(); i++) begin
      n_cmp++;
      if (rx_q[i] !== exp_b[i]) begin n_fail++; $display("FAIL overrun_byte_%0d: got %h want %h", i, rx_q[i], exp_b[i]); end
    end
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    rx_ready = 1'b1;
    rx_q.delete();
    ss_low();
    xfer_bits(8'hFF, 5, mi);
    ss_high();
    n_cmp++;
    if ({rx_valid, busy} !== 2'b00 || rx_q.size() != 0) begin
      n_fail++;
      $display("FAIL abort_partial: got valid,busy=%b count=%0d want 00 count=0", {rx_valid, busy}, rx_q.size());
    end
    ss_low();
    xfer_bits(8'h81, 8, mi);
    ss_high();
    n_cmp++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h81) begin
      n_fail++;
      $display("FAIL abort_next_byte: got count=%0d want one byte 81", rx_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi;
    rx_ready = 1'b1;
    rx_q.delete();
    ss_low();
    xfer_bits(8'hC3, 3, mi);
    put_tx(8'h77);
    n_cmp++;
    if ({busy, tx_ready} !== 2'b10) begin n_fail++; $display("FAIL pre_reset: got busy,tx_ready=%b want 10", {busy, tx_ready}); end
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    n_cmp++;
    if ({miso_t, miso_o, int_o, int_t, tx_ready, rx_valid, busy, rx_overrun, tx_underrun} !== RESET_OUTS) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %b want %b",
               {miso_t, miso_o, int_o, int_t, tx_ready, rx_valid, busy, rx_overrun, tx_underrun}, RESET_OUTS);
    end
    ss_n_i = 1'b1;
    sck_i  = 1'b0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    repeat (3) @(negedge aclk);
    ss_low();
    xfer_bits(8'h5A, 8, mi);
    ss_high();
    n_cmp++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h5A) begin
      n_fail++;
      $display("FAIL after_reset_byte: got count=%0d want one byte 5a", rx_q.size());
    end
  endtask

  task automatic test_ss_coincident();
    logic [7:0] mi;
    rx_ready = 1'b1;
    rx_q.delete();
    ovr_cnt = 0;
    ss_low();
    xfer_bits(8'hE7, 7, mi);
    mosi_i = 1'b1;
    repeat (4) @(negedge aclk);
    sck_i  = 1'b1;
    ss_n_i = 1'b1;
    repeat (4) @(negedge aclk);
    sck_i = 1'b0;
    repeat (6) @(negedge aclk);
    n_cmp++;
    if ({rx_valid, busy} !== 2'b00 || rx_q.size() != 0 || ovr_cnt != 0) begin
      n_fail++;
      $display("FAIL ss_coincident: got valid,busy=%b count=%0d overruns=%0d want 00 0 0",
               {rx_valid, busy}, rx_q.size(), ovr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_one_byte();
    test_underrun();
    test_overrun();
    test_abort();
    test_reset_mid();
    test_ss_coincident();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
